// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared encodings for the pipeline hazard controller
// Purpose: FSM state encoding, IF/ID flush NOP constant and a register-match helper.
// Ports: none (package).
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } hc_state_t;

  // Instruction loaded into IF/ID when it is flushed (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // True when the ID instruction actually reads a source that equals rd.
  function automatic logic reg_match(input logic uses, input logic [4:0] rd, input logic [4:0] rs);
    return uses && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_controller_perf_counter.sv
// rtl/hazard_controller_perf_counter.sv - wrapping event counter
// Purpose: CNT_W-bit counter that increments by one on each enabled cycle, wraps modulo 2^CNT_W.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset, clears the count
//   i_en     in   increment enable
//   o_count  out  current count
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline advance/hold/flush sequencing for the 5-stage core
// Purpose: resolves load-use stalls, taken-branch flushes and DMEM wait states, with a
//          DMEM timeout watchdog and stall/flush performance counters.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   IF_ID_REG_RS1_ADD/RS2_ADD       ID source registers
//   ID_USES_RS1/RS2                 ID instruction reads rs1/rs2
//   ID_EX_REG_RD_ADD                EX destination register
//   ID_EX_REG_MEM_CTRL_MemRead      EX instruction is a load
//   EX_BRANCH_TAKEN                 branch/jump taken in EX
//   EX_MEM_REG_DMEM_REQ, DMEM_READY MEM-stage DMEM handshake
//   PC_WRITE, IF_ID_WRITE           front-end enables
//   IF_ID_FLUSH, ID_EX_FLUSH        NOP/bubble insertion
//   BACK_WRITE                      ID/EX, EX/MEM, MEM/WB enable
//   MEM_FAULT                       sticky DMEM timeout flag
//   STALL_CNT, FLUSH_CNT            performance counters
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_REG_RS1_ADD,
  input  logic [4:0]       IF_ID_REG_RS2_ADD,
  input  logic             ID_USES_RS1,
  input  logic             ID_USES_RS2,
  input  logic [4:0]       ID_EX_REG_RD_ADD,
  input  logic             ID_EX_REG_MEM_CTRL_MemRead,
  input  logic             EX_BRANCH_TAKEN,
  input  logic             EX_MEM_REG_DMEM_REQ,
  input  logic             DMEM_READY,
  output logic             PC_WRITE,
  output logic             IF_ID_WRITE,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             BACK_WRITE,
  output logic             MEM_FAULT,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(MEM_TIMEOUT);

  hc_state_t       r_state;
  logic [TO_W-1:0] r_wait_cnt;
  logic            r_mem_fault;

  logic w_dmem_wait;
  logic w_freeze;
  logic w_load_use;
  logic w_branch_flush;
  logic w_load_stall;
  logic w_stall_inc;

  assign w_dmem_wait = EX_MEM_REG_DMEM_REQ && !DMEM_READY;
  assign w_freeze    = (r_state == ST_INIT) || (r_state == ST_FAULT) || w_dmem_wait;

  assign w_load_use = ID_EX_REG_MEM_CTRL_MemRead && (ID_EX_REG_RD_ADD != 5'd0) &&
                      (reg_match(ID_USES_RS1, ID_EX_REG_RD_ADD, IF_ID_REG_RS1_ADD) ||
                       reg_match(ID_USES_RS2, ID_EX_REG_RD_ADD, IF_ID_REG_RS2_ADD));

  // A taken branch wins over load-use: the ID instruction is wrong-path anyway.
  assign w_branch_flush = !w_freeze && EX_BRANCH_TAKEN;
  assign w_load_stall   = !w_freeze && !EX_BRANCH_TAKEN && w_load_use;

  assign PC_WRITE    = !w_freeze && !w_load_stall;
  assign IF_ID_WRITE = !w_freeze && !w_load_stall;
  assign IF_ID_FLUSH = w_branch_flush;
  assign ID_EX_FLUSH = w_branch_flush || w_load_stall;
  assign BACK_WRITE  = !w_freeze;
  assign MEM_FAULT   = r_mem_fault;

  // INIT and FAULT freeze the pipe but are not counted as stalls.
  assign w_stall_inc = (w_freeze && ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT))) ||
                       w_load_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_wait_cnt  <= '0;
      r_mem_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_dmem_wait) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= TO_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (DMEM_READY) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == TIMEOUT_V) begin
            r_state     <= ST_FAULT;
            r_mem_fault <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + TO_W'(1);
          end
        end
        default: begin
          r_state <= ST_FAULT;
        end
      endcase
    end
  end

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_stall_inc),
    .o_count (STALL_CNT)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_branch_flush),
    .o_count (FLUSH_CNT)
  );

endmodule
